// File: rtl/cam_pkg.sv
// Shared line-timing constants, sequencer state encoding and exposure clamp helper.
package cam_pkg;

    localparam int CNT_W       = 11;
    localparam int DEF_HTOT    = 136;
    localparam int DEF_VTOT    = 1027;
    localparam int DEF_ARM_CYC = 16;
    localparam int DEF_EXP_MIN = 3;
    localparam int DEF_EXP_DEF = 512;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARM       = 2'd1,
        RUN       = 2'd2,
        STOP_PEND = 2'd3
    } seq_state_t;

    function automatic logic [CNT_W-1:0] clamp_exp(input logic [CNT_W-1:0] v,
                                                   input int unsigned lo,
                                                   input int unsigned hi);
        if (v < CNT_W'(lo))
            return CNT_W'(lo);
        else if (v > CNT_W'(hi))
            return CNT_W'(hi);
        else
            return v;
    endfunction

endpackage

// File: rtl/cam_hv_cnt.sv
// ah/av counter pair: clear, load to last pixel of last line, or step with wrap.
module cam_hv_cnt
    import cam_pkg::*;
#(
    parameter int HTOT = DEF_HTOT,
    parameter int VTOT = DEF_VTOT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_ah,
    output logic [CNT_W-1:0] o_av,
    output logic             o_wrap
);

    localparam logic [CNT_W-1:0] H_MAX = CNT_W'(HTOT - 1);
    localparam logic [CNT_W-1:0] V_MAX = CNT_W'(VTOT - 1);

    logic [CNT_W-1:0] r_ah;
    logic [CNT_W-1:0] r_av;

    // Counter update: clear beats load beats increment; otherwise hold.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_ah <= '0;
            r_av <= '0;
        end else if (i_load) begin
            r_ah <= H_MAX;
            r_av <= V_MAX;
        end else if (i_inc) begin
            if (r_ah == H_MAX) begin
                r_ah <= '0;
                r_av <= (r_av == V_MAX) ? '0 : r_av + 1'b1;
            end else begin
                r_ah <= r_ah + 1'b1;
            end
        end
    end

    assign o_ah   = r_ah;
    assign o_av   = r_av;
    assign o_wrap = (r_ah == H_MAX) && (r_av == V_MAX);

endmodule

// File: rtl/cam_frame_seq.sv
// Frame/line sequencer: acquisition FSM, exposure shadow/pending register, frame counter.
module cam_frame_seq
    import cam_pkg::*;
#(
    parameter int HTOT    = DEF_HTOT,
    parameter int VTOT    = DEF_VTOT,
    parameter int ARM_CYC = DEF_ARM_CYC,
    parameter int EXP_MIN = DEF_EXP_MIN,
    parameter int EXP_DEF = DEF_EXP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_exp,
    output logic [CNT_W-1:0] ah,
    output logic [CNT_W-1:0] av,
    output logic [CNT_W-1:0] iexp,
    output logic             endet,
    output logic             frm_start,
    output logic [15:0]      frm_cnt,
    output logic             busy,
    output logic             exp_err
);

    seq_state_t       r_state;
    logic             r_mode;
    logic [15:0]      r_arm_cnt;
    logic             r_endet;
    logic             r_frm_start;
    logic [15:0]      r_frm_cnt;
    logic             r_busy;
    logic [CNT_W-1:0] r_iexp;
    logic [CNT_W-1:0] r_pend_val;
    logic             r_pend;
    logic             r_cfg_ready;
    logic             r_exp_err;

    logic             w_wrap;
    logic             w_counting;
    logic             w_boundary;
    logic             w_leave;
    logic             w_arm_last;
    logic             w_clr;
    logic             w_load;
    logic             w_inc;
    logic             w_accept;
    logic             w_clamped;
    logic [CNT_W-1:0] w_exp;

    cam_hv_cnt #(
        .HTOT (HTOT),
        .VTOT (VTOT)
    ) u_hv_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_load (w_load),
        .i_inc  (w_inc),
        .o_ah   (ah),
        .o_av   (av),
        .o_wrap (w_wrap)
    );

    assign w_counting = (r_state == RUN) || (r_state == STOP_PEND);
    assign w_boundary = w_counting && w_wrap;
    assign w_leave    = w_boundary && ((r_state == STOP_PEND) || r_mode || stop);
    assign w_arm_last = (r_arm_cnt == 16'(ARM_CYC - 1));
    assign w_accept   = cfg_valid && r_cfg_ready;
    assign w_clamped  = (cfg_exp < CNT_W'(EXP_MIN)) || (cfg_exp > CNT_W'(VTOT - 1));
    assign w_exp      = clamp_exp(cfg_exp, EXP_MIN, VTOT - 1);

    // Counter control; the ARM exit reuses the natural wrap from the loaded max position.
    always_comb begin
        w_clr  = 1'b0;
        w_load = 1'b0;
        w_inc  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_load = 1'b1;
                else       w_clr  = 1'b1;
            end
            ARM: begin
                if (stop)            w_clr = 1'b1;
                else if (w_arm_last) w_inc = 1'b1;
            end
            RUN, STOP_PEND: begin
                if (w_leave) w_clr = 1'b1;
                else         w_inc = 1'b1;
            end
            default: w_clr = 1'b1;
        endcase
    end

    // Sequencer FSM plus exposure shadow/pending handshake and frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mode      <= 1'b0;
            r_arm_cnt   <= '0;
            r_endet     <= 1'b0;
            r_frm_start <= 1'b0;
            r_frm_cnt   <= '0;
            r_busy      <= 1'b0;
            r_iexp      <= CNT_W'(EXP_DEF);
            r_pend_val  <= '0;
            r_pend      <= 1'b0;
            r_cfg_ready <= 1'b1;
            r_exp_err   <= 1'b0;
        end else begin
            r_frm_start <= 1'b0;
            r_exp_err   <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= ARM;
                        r_mode    <= mode;
                        r_arm_cnt <= '0;
                        r_endet   <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                ARM: begin
                    if (stop) begin
                        r_state <= IDLE;
                        r_endet <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (w_arm_last) begin
                        r_state     <= RUN;
                        r_frm_start <= 1'b1;
                    end else begin
                        r_arm_cnt <= r_arm_cnt + 1'b1;
                    end
                end
                RUN, STOP_PEND: begin
                    if (w_boundary) begin
                        r_frm_cnt <= r_frm_cnt + 1'b1;
                        if (w_leave) begin
                            r_state <= IDLE;
                            r_endet <= 1'b0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_frm_start <= 1'b1;
                        end
                    end else if ((r_state == RUN) && stop) begin
                        r_state <= STOP_PEND;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Pending and accept are exclusive because ready is the inverse of pending.
            if (r_pend && w_boundary) begin
                r_iexp      <= r_pend_val;
                r_pend      <= 1'b0;
                r_cfg_ready <= 1'b1;
            end

            if (w_accept) begin
                r_exp_err <= w_clamped;
                if (r_state == IDLE) begin
                    r_iexp <= w_exp;
                end else begin
                    r_pend_val  <= w_exp;
                    r_pend      <= 1'b1;
                    r_cfg_ready <= 1'b0;
                end
            end
        end
    end

    assign endet     = r_endet;
    assign frm_start = r_frm_start;
    assign frm_cnt   = r_frm_cnt;
    assign busy      = r_busy;
    assign iexp      = r_iexp;
    assign cfg_ready = r_cfg_ready;
    assign exp_err   = r_exp_err;

endmodule

// File: tb/tb_cam_frame_seq.sv
// Self-checking bench for cam_frame_seq with a short frame (HTOT=136, VTOT=8, ARM_CYC=4).
module tb_cam_frame_seq;

    localparam int HTOT    = 136;
    localparam int VTOT    = 8;
    localparam int ARM_CYC = 4;
    localparam int EXP_DEF = 512;

    typedef struct {
        int unsigned iexp;
        int unsigned cnt;
    } fs_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        mode = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [10:0] cfg_exp = '0;
    logic        cfg_ready;
    logic [10:0] ah;
    logic [10:0] av;
    logic [10:0] iexp;
    logic        endet;
    logic        frm_start;
    logic [15:0] frm_cnt;
    logic        busy;
    logic        exp_err;

    int unsigned total = 0;
    int unsigned bad = 0;
    fs_exp_t     sb_q[$];

    cam_frame_seq #(
        .HTOT    (HTOT),
        .VTOT    (VTOT),
        .ARM_CYC (ARM_CYC),
        .EXP_MIN (3),
        .EXP_DEF (EXP_DEF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_exp   (cfg_exp),
        .ah        (ah),
        .av        (av),
        .iexp      (iexp),
        .endet     (endet),
        .frm_start (frm_start),
        .frm_cnt   (frm_cnt),
        .busy      (busy),
        .exp_err   (exp_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input int unsigned e_iexp, input int unsigned e_cnt);
        fs_exp_t e;
        e.iexp = e_iexp;
        e.cnt  = e_cnt;
        sb_q.push_back(e);
    endtask

    // Every frm_start pulse must match a queued expectation.
    always @(negedge clk) begin
        if (!rst && frm_start) begin
            if (sb_q.size() == 0) begin
                check_val("fs_unexpected", 32'(frm_start), 0);
            end else begin
                fs_exp_t e;
                e = sb_q.pop_front();
                check_val("fs_ah", 32'(ah), 0);
                check_val("fs_av", 32'(av), 0);
                check_val("fs_iexp", 32'(iexp), e.iexp);
                check_val("fs_cnt", 32'(frm_cnt), e.cnt);
            end
        end
    end

    task automatic wait_for(input int unsigned x, input int unsigned y);
        int unsigned n = 0;
        while (!(ah == 11'(x) && av == 11'(y)) && n < 3000) begin
            tick();
            n++;
        end
        check_val("wait_ah", 32'(ah), x);
        check_val("wait_av", 32'(av), y);
    endtask

    task automatic check_idle(input string tag, input int unsigned e_cnt);
        check_val({tag, "_busy"}, 32'(busy), 0);
        check_val({tag, "_endet"}, 32'(endet), 0);
        check_val({tag, "_ah"}, 32'(ah), 0);
        check_val({tag, "_av"}, 32'(av), 0);
        check_val({tag, "_cnt"}, 32'(frm_cnt), e_cnt);
        check_val({tag, "_fs"}, 32'(frm_start), 0);
    endtask

    task automatic cfg_send(input int unsigned v);
        cfg_exp   = 11'(v);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("rst", 0);
        check_val("rst_iexp", 32'(iexp), EXP_DEF);
        check_val("rst_ready", 32'(cfg_ready), 1);
        check_val("rst_err", 32'(exp_err), 0);

        // Continuous mode: arm, one full frame, then stop at av=2.
        mode  = 1'b0;
        start = 1'b1;
        sb_push(EXP_DEF, 0);
        tick();
        start = 1'b0;
        for (int i = 0; i < ARM_CYC; i++) begin
            check_val("arm_endet", 32'(endet), 1);
            check_val("arm_busy", 32'(busy), 1);
            check_val("arm_ah", 32'(ah), HTOT - 1);
            check_val("arm_av", 32'(av), VTOT - 1);
            if (i < ARM_CYC - 1) tick();
        end
        sb_push(EXP_DEF, 1);
        tick();
        check_val("run0_fs", 32'(frm_start), 1);
        check_val("run0_busy", 32'(busy), 1);
        for (int i = 0; i < HTOT * VTOT; i++) tick();
        check_val("frame1_cnt", 32'(frm_cnt), 1);
        check_val("frame1_fs", 32'(frm_start), 1);
        wait_for(0, 2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_val("stoppend_busy", 32'(busy), 1);
        wait_for(HTOT - 1, VTOT - 1);
        check_val("stoppend_cnt", 32'(frm_cnt), 1);
        check_val("stoppend_endet", 32'(endet), 1);
        tick();
        check_idle("stop_av2", 2);
        for (int i = 0; i < 20; i++) tick();

        // Single-frame mode.
        mode  = 1'b1;
        start = 1'b1;
        sb_push(EXP_DEF, 2);
        tick();
        start = 1'b0;
        mode  = 1'b0;
        for (int i = 0; i < ARM_CYC; i++) tick();
        wait_for(HTOT - 1, VTOT - 1);
        check_val("single_cnt_pre", 32'(frm_cnt), 2);
        tick();
        check_idle("single", 3);
        for (int i = 0; i < 2 * HTOT; i++) tick();
        check_val("single_stay_busy", 32'(busy), 0);

        // Exposure update mid-frame, then stop on the boundary cycle.
        start = 1'b1;
        sb_push(EXP_DEF, 3);
        tick();
        start = 1'b0;
        for (int i = 0; i < ARM_CYC; i++) tick();
        wait_for(0, 3);
        check_val("cfg_ready_pre", 32'(cfg_ready), 1);
        cfg_send(5);
        check_val("cfg_ready_drop", 32'(cfg_ready), 0);
        check_val("cfg_iexp_hold", 32'(iexp), EXP_DEF);
        check_val("cfg_err_none", 32'(exp_err), 0);
        wait_for(HTOT - 1, VTOT - 1);
        check_val("cfg_iexp_bnd", 32'(iexp), EXP_DEF);
        check_val("cfg_ready_bnd", 32'(cfg_ready), 0);
        sb_push(5, 4);
        tick();
        check_val("cfg_iexp_new", 32'(iexp), 5);
        check_val("cfg_ready_back", 32'(cfg_ready), 1);
        wait_for(HTOT - 1, VTOT - 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_idle("stop_bnd", 5);
        for (int i = 0; i < 20; i++) tick();

        // Clamping and direct write in IDLE.
        cfg_send(1);
        check_val("clamp_lo_iexp", 32'(iexp), 3);
        check_val("clamp_lo_err", 32'(exp_err), 1);
        tick();
        check_val("clamp_lo_err_end", 32'(exp_err), 0);
        cfg_send(2000);
        check_val("clamp_hi_iexp", 32'(iexp), VTOT - 1);
        check_val("clamp_hi_err", 32'(exp_err), 1);
        tick();
        check_val("clamp_hi_err_end", 32'(exp_err), 0);
        cfg_send(6);
        check_val("noclamp_iexp", 32'(iexp), 6);
        check_val("noclamp_err", 32'(exp_err), 0);
        check_val("idle_ready", 32'(cfg_ready), 1);

        // Reset mid-frame with an update pending, then restart.
        start = 1'b1;
        sb_push(6, 5);
        tick();
        start = 1'b0;
        for (int i = 0; i < ARM_CYC; i++) tick();
        wait_for(0, 2);
        cfg_send(4);
        check_val("rstmid_ready_low", 32'(cfg_ready), 0);
        wait_for(50, 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("rstmid", 0);
        check_val("rstmid_iexp", 32'(iexp), EXP_DEF);
        check_val("rstmid_ready", 32'(cfg_ready), 1);
        start = 1'b1;
        sb_push(EXP_DEF, 0);
        tick();
        start = 1'b0;
        check_val("restart_endet", 32'(endet), 1);
        check_val("restart_ah", 32'(ah), HTOT - 1);
        check_val("restart_av", 32'(av), VTOT - 1);
        for (int i = 0; i < ARM_CYC; i++) tick();
        check_val("restart_fs", 32'(frm_start), 1);
        check_val("restart_busy", 32'(busy), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_for(HTOT - 1, VTOT - 1);
        tick();
        check_idle("restart_stop", 1);
        tick();
        check_val("sb_empty", 32'(sb_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
